sub_16bit_serial: RTL and testbench

//  Multi-cycle digit-serial subtractor, the inverse operation of the adder_16bit datapath.
//  - Computes diff = a - b - bin with borrow-out and signed-overflow flags.
//  - Processes DIGIT bits per clock; valid/ready handshakes on both sides.
//  - Sits between operand staging and the result register file.

---
 rtl/sub_pkg.sv | 20 ++
 rtl/sub_digit.sv | 21 ++
 rtl/sub_16bit_serial.sv | 168 ++++++++++++++++
 tb/tb_sub_16bit_serial.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared types and sizing for the digit-serial subtractor.
package sub_pkg;

    // Counter width helper that stays at least one bit wide.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned SUB_WIDTH = 16;
    localparam int unsigned SUB_DIGIT = 4;
    localparam int unsigned NDIG      = SUB_WIDTH / SUB_DIGIT;
    localparam int unsigned CNT_W     = cnt_width(NDIG);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sub_digit.sv
// Combinational DIGIT-bit subtract slice: d = x - y - bi, bo = borrow-out.
module sub_digit #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             bi,
    output logic [DIGIT-1:0] d,
    output logic             bo
);

    logic [DIGIT:0] ext;

    // One extra bit catches the borrow as the sign of the widened difference.
    always_comb begin
        ext = {1'b0, x} - {1'b0, y} - (DIGIT+1)'(bi);
        d   = ext[DIGIT-1:0];
        bo  = ext[DIGIT];
    end

endmodule

// File: rtl/sub_16bit_serial.sv
// Digit-serial subtractor: diff = a - b - bin, DIGIT bits per clock, LSB first.
// Optional feature: define SUB_SATURATE_EN to clamp diff on signed overflow.
module sub_16bit_serial
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_WIDTH,
    parameter int unsigned DIGIT = SUB_DIGIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             overflow
);

    localparam int unsigned N_DIG = WIDTH / DIGIT;
    localparam int unsigned C_W   = cnt_width(N_DIG);
    localparam int unsigned ACC_W = WIDTH - DIGIT;

    state_t             state_q,     state_d;
    logic [C_W-1:0]     cnt_q,       cnt_d;
    logic [WIDTH-1:0]   a_sh_q,      a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,      b_sh_d;
    logic [ACC_W-1:0]   acc_q,       acc_d;
    logic               borrow_q,    borrow_d;
    logic               a_msb_q,     a_msb_d;
    logic               b_msb_q,     b_msb_d;
    logic [WIDTH-1:0]   diff_q,      diff_d;
    logic               bout_q,      bout_d;
    logic               ovf_q,       ovf_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [DIGIT-1:0]   slice_d;
    logic               slice_bo;
    logic [WIDTH-1:0]   raw_diff;
    logic               raw_ovf;

    // Single slice reused every RUN cycle on the low digit of the shifters.
    sub_digit #(.DIGIT(DIGIT)) u_digit (
        .x  (a_sh_q[DIGIT-1:0]),
        .y  (b_sh_q[DIGIT-1:0]),
        .bi (borrow_q),
        .d  (slice_d),
        .bo (slice_bo)
    );

    // Full result as it looks once the final slice joins the accumulated ones.
    always_comb begin
        raw_diff = {slice_d, acc_q};
        raw_ovf  = (a_msb_q != b_msb_q) && (raw_diff[WIDTH-1] != a_msb_q);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        acc_d       = acc_q;
        borrow_d    = borrow_q;
        a_msb_d     = a_msb_q;
        b_msb_d     = b_msb_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    a_sh_d     = a;
                    b_sh_d     = b;
                    borrow_d   = bin;
                    a_msb_d    = a[WIDTH-1];
                    b_msb_d    = b[WIDTH-1];
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                a_sh_d   = a_sh_q >> DIGIT;
                b_sh_d   = b_sh_q >> DIGIT;
                acc_d    = {slice_d, acc_q[ACC_W-1:DIGIT]};
                borrow_d = slice_bo;
                cnt_d    = cnt_q + C_W'(1);
                if (cnt_q == C_W'(N_DIG - 1)) begin
`ifdef SUB_SATURATE_EN
                    if (raw_ovf) begin
                        diff_d = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
                    end else begin
                        diff_d = raw_diff;
                    end
`else
                    diff_d = raw_diff;
`endif
                    bout_d      = slice_bo;
                    ovf_d       = raw_ovf;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State register; reset aborts any op and clears all outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            acc_q       <= '0;
            borrow_q    <= 1'b0;
            a_msb_q     <= 1'b0;
            b_msb_q     <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            acc_q       <= acc_d;
            borrow_q    <= borrow_d;
            a_msb_q     <= a_msb_d;
            b_msb_q     <= b_msb_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_sub_16bit_serial.sv
// Directed self-checking bench for sub_16bit_serial (honours SUB_SATURATE_EN).
module tb_sub_16bit_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    sub_16bit_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands once in_ready is seen, hold for one edge, then drop.
    task automatic start_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                            input logic bv_in);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_wait"}, 32'(in_ready), 32'd1);
        a        = av;
        b        = bv;
        bin      = bv_in;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
    endtask

    // Count cycles from acceptance to out_valid, bounded.
    task automatic wait_done(input string tag);
        int n;
        n = 1;
        @(negedge clk);
        while (out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd4);
    endtask

    // Check result, handshake it away, confirm return to idle with values retained.
    task automatic finish_op(input string tag, input logic [15:0] ed, input logic eb,
                             input logic eo);
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_bout"}, 32'(bout), 32'(eb));
        check({tag, "_ovf"},  32'(overflow), 32'(eo));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(in_ready), 32'd1);
        check({tag, "_diff_kept"},  32'(diff), 32'(ed));
    endtask

    initial begin
        logic [15:0] exp3;
        logic [15:0] exp4;
`ifdef SUB_SATURATE_EN
        exp3 = 16'h8000;
        exp4 = 16'h7FFF;
`else
        exp3 = 16'h7FFF;
        exp4 = 16'h8000;
`endif
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff",      32'(diff),      32'd0);
        check("rst_bout",      32'(bout),      32'd0);
        check("rst_ovf",       32'(overflow),  32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_release_ready", 32'(in_ready), 32'd1);

        // 1: basic
        start_op("t1", 16'h0005, 16'h0003, 1'b0);
        wait_done("t1");
        finish_op("t1", 16'h0002, 1'b0, 1'b0);

        // 2: underflow wrap and borrow-in
        start_op("t2a", 16'h0000, 16'h0001, 1'b0);
        wait_done("t2a");
        finish_op("t2a", 16'hFFFF, 1'b1, 1'b0);
        start_op("t2b", 16'h0010, 16'h0010, 1'b1);
        wait_done("t2b");
        finish_op("t2b", 16'hFFFF, 1'b1, 1'b0);

        // 3, 4: signed overflow both directions
        start_op("t3", 16'h8000, 16'h0001, 1'b0);
        wait_done("t3");
        finish_op("t3", exp3, 1'b0, 1'b1);
        start_op("t4", 16'h7FFF, 16'hFFFF, 1'b0);
        wait_done("t4");
        finish_op("t4", exp4, 1'b1, 1'b1);

        // 5: operands changed mid-run, result held under backpressure
        start_op("t5", 16'h1111, 16'h0011, 1'b0);
        a   = 16'hFFFF;
        b   = 16'h0F0F;
        bin = 1'b1;
        wait_done("t5");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_hold_valid", 32'(out_valid), 32'd1);
            check("t5_hold_diff",  32'(diff),      32'h1100);
            check("t5_hold_ready", 32'(in_ready),  32'd0);
        end
        finish_op("t5", 16'h1100, 1'b0, 1'b0);

        // 6: reset during RUN at cnt=2 aborts the op
        start_op("t6", 16'hFFFF, 16'h0001, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6_abort_valid", 32'(out_valid), 32'd0);
        check("t6_abort_ready", 32'(in_ready),  32'd0);
        check("t6_abort_diff",  32'(diff),      32'd0);
        check("t6_abort_bout",  32'(bout),      32'd0);
        check("t6_abort_ovf",   32'(overflow),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (out_valid === 1'b1) seen++;
            end
            check("t6_no_valid", 32'(seen), 32'd0);
        end
        start_op("t6n", 16'h1234, 16'h0234, 1'b0);
        wait_done("t6n");
        finish_op("t6n", 16'h1000, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
